branch_update_queue: RTL

Buffers resolved branch outcomes from the execute/commit side and drains them in order, one per cycle, into the 32-entry branch prediction table's update port. It sits directly upstream of the predictor. Bursts of resolved branches therefore never collide at the table's single write port. Optional performance counters track update and mispredict totals.

---
 rtl/branch_update_queue_if.sv | 35 +++
 rtl/branch_update_queue.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/branch_update_queue_if.sv
// rtl/branch_update_queue_if.sv - resolved-branch push side, predictor update side and status of branch_update_queue
interface branch_update_queue_if #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 5,
    parameter int CNT_W = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             valid_i;
    logic             ready_o;
    logic [IDX_W-1:0] brAddr_i;
    logic             brTaken_i;
    logic             brMispredict_i;
    logic             hold_i;
    logic             anUpdate_o;
    logic [IDX_W-1:0] branchAddrWrite_o;
    logic             brTaken_o;
    logic [CW-1:0]    count_o;
    logic             full_o;
    logic             empty_o;
    logic [CNT_W-1:0] updates_o;
    logic [CNT_W-1:0] mispredicts_o;

    modport slave (
        input  valid_i, brAddr_i, brTaken_i, brMispredict_i, hold_i,
        output ready_o, anUpdate_o, branchAddrWrite_o, brTaken_o,
        output count_o, full_o, empty_o, updates_o, mispredicts_o
    );

    modport master (
        output valid_i, brAddr_i, brTaken_i, brMispredict_i, hold_i,
        input  ready_o, anUpdate_o, branchAddrWrite_o, brTaken_o,
        input  count_o, full_o, empty_o, updates_o, mispredicts_o
    );
endinterface

// File: rtl/branch_update_queue.sv
// rtl/branch_update_queue.sv - in-order FIFO of resolved branches draining one update per cycle into the predictor
// Optional update/mispredict counters are enabled with `define BRQ_STATS_EN.
module branch_update_queue #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 5,
    parameter int CNT_W = 16
) (
    input logic                   clk_i,
    input logic                   reset_i,
    branch_update_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef BRQ_STATS_EN
    localparam int ENT_W = IDX_W + 2;
`else
    localparam int ENT_W = IDX_W + 1;
`endif

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             upd_q, upd_d;
    logic [IDX_W-1:0] addr_q, addr_d;
    logic             taken_q, taken_d;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] wr_entry;
    logic [ENT_W-1:0] rd_entry;

    // Status depends on the registered count only, so ready never
    // combinationally follows valid or hold.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.valid_i && !full;
    assign pop   = !empty && !bus.hold_i;

`ifdef BRQ_STATS_EN
    assign wr_entry = {bus.brMispredict_i, bus.brTaken_i, bus.brAddr_i};
`else
    assign wr_entry = {bus.brTaken_i, bus.brAddr_i};
`endif
    assign rd_entry = mem_q[rp_q];

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        upd_d   = 1'b0;
        addr_d  = addr_q;
        taken_d = taken_q;
        if (push) begin
            wp_d = wp_q + PTR_W'(1);
        end
        if (pop) begin
            rp_d    = rp_q + PTR_W'(1);
            upd_d   = 1'b1;
            addr_d  = rd_entry[IDX_W-1:0];
            taken_d = rd_entry[IDX_W];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            upd_q   <= 1'b0;
            addr_q  <= '0;
            taken_q <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            upd_q   <= upd_d;
            addr_q  <= addr_d;
            taken_q <= taken_d;
        end
    end

    // Storage carries no reset: a cleared count/pointer set makes old contents unreachable.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wp_q] <= wr_entry;
        end
    end

    assign bus.ready_o           = !full;
    assign bus.full_o            = full;
    assign bus.empty_o           = empty;
    assign bus.count_o           = count_q;
    assign bus.anUpdate_o        = upd_q;
    assign bus.branchAddrWrite_o = addr_q;
    assign bus.brTaken_o         = taken_q;

`ifdef BRQ_STATS_EN
    logic [CNT_W-1:0] updates_q, updates_d;
    logic [CNT_W-1:0] mispredicts_q, mispredicts_d;
    logic             unused_rd_mispredict;

    // The stored mispredict bit travels with the entry but statistics count it at acceptance.
    assign unused_rd_mispredict = rd_entry[IDX_W+1];

    always_comb begin
        updates_d     = updates_q;
        mispredicts_d = mispredicts_q;
        if (pop && (updates_q != {CNT_W{1'b1}})) begin
            updates_d = updates_q + CNT_W'(1);
        end
        if (push && bus.brMispredict_i && (mispredicts_q != {CNT_W{1'b1}})) begin
            mispredicts_d = mispredicts_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            updates_q     <= '0;
            mispredicts_q <= '0;
        end else begin
            updates_q     <= updates_d;
            mispredicts_q <= mispredicts_d;
        end
    end

    assign bus.updates_o     = updates_q;
    assign bus.mispredicts_o = mispredicts_q;
`else
    logic unused_mispredict_in;

    assign unused_mispredict_in = bus.brMispredict_i;
    assign bus.updates_o        = '0;
    assign bus.mispredicts_o    = '0;
`endif

endmodule
